fetch_branch_unit: RTL

Instruction fetch and branch-resolution stage that sits directly upstream of the datapath. It holds the 8-bit program counter, fetches 16-bit instructions from synchronous memory, and hands each one to the execute controller with a valid/ready handshake. It drives the datapath `PC` input with the link value and, when execution completes, picks the next PC from the datapath status flags (`Z_out`) or a register value (`datapath_out`).

---
 rtl/fetch_branch_unit.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/fetch_branch_unit.sv
// Fetch/branch stage: FETCH->LATCH->ISSUE->WAIT_EXEC, one instruction in flight, min 4 cycles each.
// ir is held in ISSUE until ir_ready; next PC is chosen in the exec_done cycle from status/rd_val.
module fetch_branch_unit #(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [15:0]     mem_rdata,
  output logic [PC_W-1:0] mem_addr,
  output logic            mem_read,
  output logic [15:0]     ir,
  output logic            ir_valid,
  input  logic            ir_ready,
  input  logic            exec_done,
  input  logic [2:0]      status,
  input  logic [15:0]     rd_val,
  output logic [PC_W-1:0] link_pc,
  output logic            halt
);

  typedef enum logic [2:0] {
    S_RESET,
    S_FETCH,
    S_LATCH,
    S_ISSUE,
    S_WAIT,
    S_HALT
  } state_t;

  typedef struct packed {
    logic [2:0] opcode;
    logic [1:0] op;
    logic [2:0] cond;
    logic [7:0] imm8;
  } instr_t;

  localparam logic [2:0] OPC_BRANCH = 3'b001;
  localparam logic [2:0] OPC_LINK   = 3'b010;
  localparam logic [2:0] OPC_HALT   = 3'b111;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     ir_q, ir_d;
  logic            ir_valid_q, ir_valid_d;
  logic            halt_q, halt_d;

  instr_t          ir_f;
  logic [PC_W-1:0] sximm;
  logic [PC_W-1:0] pc_rel;
  logic [PC_W-1:0] next_pc;
  logic            flag_z, flag_n, flag_v;
  logic            cond_true;
  logic            unused_rd_hi;

  assign ir_f   = instr_t'(ir_q);
  assign sximm  = PC_W'($signed(ir_f.imm8));
  assign pc_rel = pc_q + sximm;
  assign flag_z = status[0];
  assign flag_n = status[1];
  assign flag_v = status[2];
  assign unused_rd_hi = ^rd_val[15:PC_W];

  always_comb begin
    cond_true = 1'b0;
    case (ir_f.cond)
      3'b000:  cond_true = 1'b1;
      3'b001:  cond_true = flag_z;
      3'b010:  cond_true = !flag_z;
      3'b011:  cond_true = flag_n ^ flag_v;
      3'b100:  cond_true = (flag_n ^ flag_v) | flag_z;
      default: cond_true = 1'b0;
    endcase
  end

  // pc already points one past the instruction, so relative targets add to pc_q directly
  always_comb begin
    next_pc = pc_q;
    if (ir_f.opcode == OPC_BRANCH && ir_f.op == 2'b00) begin
      if (cond_true) next_pc = pc_rel;
    end else if (ir_f.opcode == OPC_LINK) begin
      case (ir_f.op)
        2'b11:         next_pc = pc_rel;
        2'b00, 2'b10:  next_pc = rd_val[PC_W-1:0];
        default:       next_pc = pc_q;
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    ir_valid_d = ir_valid_q;
    halt_d     = halt_q;
    case (state_q)
      S_RESET: state_d = S_FETCH;
      S_FETCH: state_d = S_LATCH;
      S_LATCH: begin
        ir_d = mem_rdata;
        pc_d = pc_q + PC_W'(1);
        if (mem_rdata[15:13] == OPC_HALT) begin
          state_d = S_HALT;
          halt_d  = 1'b1;
        end else begin
          state_d    = S_ISSUE;
          ir_valid_d = 1'b1;
        end
      end
      S_ISSUE: begin
        if (ir_valid_q && ir_ready) begin
          ir_valid_d = 1'b0;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (exec_done) begin
          pc_d    = next_pc;
          state_d = S_FETCH;
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_RESET;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_RESET;
      pc_q       <= RESET_PC;
      ir_q       <= '0;
      ir_valid_q <= 1'b0;
      halt_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
      halt_q     <= halt_d;
    end
  end

  assign mem_addr = pc_q;
  assign link_pc  = pc_q;
  assign mem_read = (state_q == S_FETCH);
  assign ir       = ir_q;
  assign ir_valid = ir_valid_q;
  assign halt     = halt_q;

endmodule
